nand_bus_seq: RTL and testbench
===============================

// Module: nand_bus_seq
// PURPOSE
//  Parametrised NAND bus sequencer; next generation of the flash_ctrl mode engine.
//  Pops 32-bit instructions from the core instruction queue, drives the ONFI-style pins for NUM_CE dies.
//  Adds per-instruction CE select, programmable strobe timing, data-stream stalls, R/B wait with timeout.
// PARAMETERS
//  NUM_CE      4      chip enables / R/B inputs (1..16)
//  DW          8      flash data bus width (8 or 16)
//  REP_W       8      repeat field width (<=12); op runs rep+1 bus cycles
//  T_LO        2      clocks WE_N/RE_N held low per bus cycle (>=1)
//  T_HI        2      clocks WE_N/RE_N held high per bus cycle (>=1)
//  T_WB        8      clocks R/B ignored after WAIT_RB starts
//  RB_TIMEOUT  65535  clocks allowed for R/B high before error
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous reset, active-high
//  instr       in   32      [3:0] op, [4+REP_W-1:4] rep, [19:16] ce index
//  instr_valid in   1       instruction queue not empty
//  instr_ready out  1       instruction accepted this cycle (pop)
//  wr_data     in   DW      cmd/addr/data byte from core stream
//  wr_valid    in   1       wr_data available
//  wr_ready    out  1       wr_data consumed this cycle (pop)
//  rd_data     out  DW      byte read from flash
//  rd_valid    out  1       rd_data valid, one-cycle pulse
//  rd_full     in   1       read fifo full; blocks next read cycle
//  ce_n        out  NUM_CE  chip enables, active-low
//  cle, ale    out  1       command / address latch enable
//  we_n, re_n  out  1       write / read strobes
//  wp_n        out  1       write protect, active-low
//  rb_n        in   NUM_CE  ready/busy, async, 2-FF synchronised inside
//  dq_out      out  DW      flash data out;  dq_oe out 1: tri-state enable
//  dq_in       in   DW      flash data in
//  busy        out  1       state != FETCH
//  err_illegal out  1       sticky: bad op or ce>=NUM_CE;  err_timeout out 1: sticky R/B timeout
// BEHAVIOUR
//  Reset (rst=1 at edge): ce_n all 1, cle=ale=0, we_n=re_n=1, wp_n=0, dq_oe=0, dq_out=0, rd_valid=0,
//   instr_ready=0, wr_ready=0, errors cleared, state FETCH. Mid-op reset aborts instantly, no byte completes.
//  Ops: 0 STANDBY(all ce_n=1) 1 IDLE(select ce) 2 CMD 3 ADDR 4 DIN 5 DOUT 6 WP_ON(wp_n=0) 7 WP_OFF(wp_n=1)
//   8 WAIT_RB; 9-15 illegal -> err_illegal set, instr consumed, outputs unchanged. ce held until changed.
//  States: FETCH, SETUP, LO, HI, STALL, RB.
//  FETCH: instr_ready=instr_valid; ops 0,1,6,7 complete in this cycle; 2-5 -> SETUP; 8 -> RB.
//  SETUP (1 clk): ce_n[ce]=0, cle=(op2), ale=(op3), dq_oe=(op2..4), strobes high.
//  Byte cycle: LO T_LO clks then HI T_HI clks; ops 2-4 pulse we_n, op 5 pulses re_n.
//   Entry to LO for ops 2-4 requires wr_valid: wr_ready pulses on that edge, dq_out loads wr_data.
//   Entry to LO for op 5 requires !rd_full. Unmet condition -> STALL: strobes high, cle/ale/dq held.
//   DOUT: dq_in sampled on last LO clock; rd_valid pulses the cycle re_n returns high.
//  End of HI: rep_cnt==0 -> FETCH (cle/ale/dq_oe drop); else rep_cnt-1 -> LO/STALL, no bubble.
//  Throughput: one byte per T_LO+T_HI clks; single-byte instr = 1+T_LO+T_HI clks after accept.
//  RB: ignore T_WB clks, then exit to FETCH when synced rb_n[ce]=1; after RB_TIMEOUT clks set
//   err_timeout and exit. ce_n stays low throughout.
//  rep field zero-extended; ce compare uses full 4-bit field.
// TESTING
//  1 rst 2 clks -> ce_n=4'hF, we_n=re_n=1, wp_n=0, busy=0; instr_ready=1 once instr_valid.
//  2 instr=0x0002_0002, wr_data=0x70 -> ce_n=4'b1011, cle=1, one we_n low 2 clks, one wr_ready, FETCH after 5 clks.
//  3 instr=0x0000_0043, wr_data 0x11..0x55 -> 5 ale strobes, 5 pops, dq_out matches each we_n rise, 20 clks of LO/HI.
//  4 instr=0x0000_0034 (DIN rep3), wr_valid low after byte 2 -> STALL, we_n high; resume, 4 bytes, none lost/duplicated.
//  5 instr=0x0000_0025, dq_in 0xA5,0x5A,0x3C; rd_full high 10 clks mid-burst -> re_n held; rd_valid x3 in order.
//  6 WAIT_RB, RB_TIMEOUT=100, rb_n[0]=0 -> err_timeout at ~110 clks; rb_n release -> FETCH <=3 clks; op 0xF -> err_illegal.

Source files
------------

// File: rtl/nand_bus_if.sv
// Pin and queue bundle between the NAND bus sequencer and its core / flash neighbours.
// The master side is the sequencer; the slave side is whatever feeds it and the flash dies.
interface nand_bus_if #(
    parameter int NUM_CE = 4,
    parameter int DW     = 8
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_full;
    logic [NUM_CE-1:0] ce_n;
    logic              cle;
    logic              ale;
    logic              we_n;
    logic              re_n;
    logic              wp_n;
    logic [NUM_CE-1:0] rb_n;
    logic [DW-1:0]     dq_out;
    logic              dq_oe;
    logic [DW-1:0]     dq_in;
    logic              busy;
    logic              err_illegal;
    logic              err_timeout;

    modport master (
        input  instr, instr_valid, wr_data, wr_valid, rd_full, rb_n, dq_in,
        output instr_ready, wr_ready, rd_data, rd_valid, ce_n, cle, ale, we_n, re_n,
               wp_n, dq_out, dq_oe, busy, err_illegal, err_timeout
    );

    modport slave (
        output instr, instr_valid, wr_data, wr_valid, rd_full, rb_n, dq_in,
        input  instr_ready, wr_ready, rd_data, rd_valid, ce_n, cle, ale, we_n, re_n,
               wp_n, dq_out, dq_oe, busy, err_illegal, err_timeout
    );
endinterface

// File: rtl/nand_bus_seq.sv
// NAND bus sequencer: pops 32-bit instructions and drives ONFI-style pins for NUM_CE dies,
// with programmable strobe timing, stream stalls and R/B wait with timeout.
module nand_bus_seq #(
    parameter int NUM_CE     = 4,
    parameter int DW         = 8,
    parameter int REP_W      = 8,
    parameter int T_LO       = 2,
    parameter int T_HI       = 2,
    parameter int T_WB       = 8,
    parameter int RB_TIMEOUT = 65535
) (
    input logic        clk,
    input logic        rst,
    nand_bus_if.master bus
);
    localparam int TMAX = (T_LO > T_HI) ? T_LO : T_HI;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RBW  = $clog2(T_WB + RB_TIMEOUT + 2);
    localparam logic [RBW-1:0] WB_END = RBW'(T_WB);
    localparam logic [RBW-1:0] TO_END = RBW'(T_WB + RB_TIMEOUT);

    localparam logic [3:0] OP_STANDBY = 4'd0;
    localparam logic [3:0] OP_IDLE    = 4'd1;
    localparam logic [3:0] OP_CMD     = 4'd2;
    localparam logic [3:0] OP_ADDR    = 4'd3;
    localparam logic [3:0] OP_DIN     = 4'd4;
    localparam logic [3:0] OP_DOUT    = 4'd5;
    localparam logic [3:0] OP_WP_ON   = 4'd6;
    localparam logic [3:0] OP_WP_OFF  = 4'd7;
    localparam logic [3:0] OP_WAIT_RB = 4'd8;

    typedef enum logic [2:0] {FETCH, SETUP, LO, HI, STALL, RB} state_t;

    typedef struct packed {
        logic [3:0]       ce;
        logic [REP_W-1:0] rep;
        logic [3:0]       op;
    } instr_t;

    instr_t            dec;
    logic [NUM_CE-1:0] ce_in_oh;
    logic              ce_ok;
    logic              unused_instr;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [NUM_CE-1:0] ce_oh_q, ce_oh_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [RBW-1:0]    rb_cnt_q, rb_cnt_d;
    logic [NUM_CE-1:0] ce_n_q, ce_n_d;
    logic              cle_q, cle_d, ale_q, ale_d;
    logic              we_n_q, we_n_d, re_n_q, re_n_d, wp_n_q, wp_n_d;
    logic [DW-1:0]     dq_out_q, dq_out_d, rd_data_q, rd_data_d;
    logic              dq_oe_q, dq_oe_d, rd_valid_q, rd_valid_d;
    logic              err_ill_q, err_ill_d, err_to_q, err_to_d;
    logic [NUM_CE-1:0] rb_s1, rb_s2;

    logic instr_ready_c, wr_ready_c, lo_req, is_wr, can_go, rb_sel;

    assign dec          = '{ce: bus.instr[19:16], rep: bus.instr[4 +: REP_W], op: bus.instr[3:0]};
    assign unused_instr = ^bus.instr;

    always_comb begin
        ce_in_oh = '0;
        for (int i = 0; i < NUM_CE; i++) ce_in_oh[i] = (dec.ce == 4'(i));
    end
    // The full 4-bit ce field must land on an existing die.
    assign ce_ok  = |ce_in_oh;

    assign is_wr  = (op_q == OP_CMD) || (op_q == OP_ADDR) || (op_q == OP_DIN);
    assign can_go = is_wr ? bus.wr_valid : !bus.rd_full;
    assign rb_sel = |(rb_s2 & ce_oh_q);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ce_oh_d       = ce_oh_q;
        rep_d         = rep_q;
        tmr_d         = tmr_q;
        rb_cnt_d      = rb_cnt_q;
        ce_n_d        = ce_n_q;
        cle_d         = cle_q;
        ale_d         = ale_q;
        we_n_d        = we_n_q;
        re_n_d        = re_n_q;
        wp_n_d        = wp_n_q;
        dq_out_d      = dq_out_q;
        dq_oe_d       = dq_oe_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        err_ill_d     = err_ill_q;
        err_to_d      = err_to_q;
        instr_ready_c = 1'b0;
        wr_ready_c    = 1'b0;
        lo_req        = 1'b0;

        case (state_q)
            FETCH: begin
                if (bus.instr_valid) begin
                    instr_ready_c = 1'b1;
                    op_d          = dec.op;
                    case (dec.op)
                        OP_STANDBY: ce_n_d = '1;
                        OP_WP_ON:   wp_n_d = 1'b0;
                        OP_WP_OFF:  wp_n_d = 1'b1;
                        OP_IDLE: begin
                            if (ce_ok) begin
                                ce_n_d  = ~ce_in_oh;
                                ce_oh_d = ce_in_oh;
                            end else err_ill_d = 1'b1;
                        end
                        OP_CMD, OP_ADDR, OP_DIN, OP_DOUT: begin
                            if (ce_ok) begin
                                ce_n_d  = ~ce_in_oh;
                                ce_oh_d = ce_in_oh;
                                rep_d   = dec.rep;
                                cle_d   = (dec.op == OP_CMD);
                                ale_d   = (dec.op == OP_ADDR);
                                dq_oe_d = (dec.op != OP_DOUT);
                                state_d = SETUP;
                            end else err_ill_d = 1'b1;
                        end
                        OP_WAIT_RB: begin
                            if (ce_ok) begin
                                ce_n_d   = ~ce_in_oh;
                                ce_oh_d  = ce_in_oh;
                                rb_cnt_d = '0;
                                state_d  = RB;
                            end else err_ill_d = 1'b1;
                        end
                        default: err_ill_d = 1'b1;
                    endcase
                end
            end
            SETUP, STALL: lo_req = 1'b1;
            LO: begin
                if (tmr_q == '0) begin
                    state_d = HI;
                    tmr_d   = TW'(T_HI - 1);
                    we_n_d  = 1'b1;
                    re_n_d  = 1'b1;
                    if (op_q == OP_DOUT) begin
                        rd_data_d  = bus.dq_in;
                        rd_valid_d = 1'b1;
                    end
                end else tmr_d = tmr_q - TW'(1);
            end
            HI: begin
                if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
                else if (rep_q == '0) begin
                    state_d = FETCH;
                    cle_d   = 1'b0;
                    ale_d   = 1'b0;
                    dq_oe_d = 1'b0;
                end else begin
                    rep_d  = rep_q - REP_W'(1);
                    lo_req = 1'b1;
                end
            end
            RB: begin
                // R/B is only trusted once the T_WB window after the command has passed.
                if (rb_cnt_q >= WB_END && rb_sel) state_d = FETCH;
                else if (rb_cnt_q >= TO_END) begin
                    err_to_d = 1'b1;
                    state_d  = FETCH;
                end else rb_cnt_d = rb_cnt_q + RBW'(1);
            end
            default: state_d = FETCH;
        endcase

        // Shared entry into a byte cycle from SETUP, STALL or back-to-back from HI.
        if (lo_req) begin
            if (can_go) begin
                state_d = LO;
                tmr_d   = TW'(T_LO - 1);
                if (is_wr) begin
                    we_n_d     = 1'b0;
                    wr_ready_c = 1'b1;
                    dq_out_d   = bus.wr_data;
                end else re_n_d = 1'b0;
            end else state_d = STALL;
        end
    end

    always_ff @(posedge clk) begin
        rb_s1 <= bus.rb_n;
        rb_s2 <= rb_s1;
        if (rst) begin
            state_q    <= FETCH;
            op_q       <= OP_STANDBY;
            ce_oh_q    <= '0;
            rep_q      <= '0;
            tmr_q      <= '0;
            rb_cnt_q   <= '0;
            ce_n_q     <= '1;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            we_n_q     <= 1'b1;
            re_n_q     <= 1'b1;
            wp_n_q     <= 1'b0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_ill_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ce_oh_q    <= ce_oh_d;
            rep_q      <= rep_d;
            tmr_q      <= tmr_d;
            rb_cnt_q   <= rb_cnt_d;
            ce_n_q     <= ce_n_d;
            cle_q      <= cle_d;
            ale_q      <= ale_d;
            we_n_q     <= we_n_d;
            re_n_q     <= re_n_d;
            wp_n_q     <= wp_n_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_ill_q  <= err_ill_d;
            err_to_q   <= err_to_d;
        end
    end

    assign bus.instr_ready = instr_ready_c & ~rst;
    assign bus.wr_ready    = wr_ready_c & ~rst;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.ce_n        = ce_n_q;
    assign bus.cle         = cle_q;
    assign bus.ale         = ale_q;
    assign bus.we_n        = we_n_q;
    assign bus.re_n        = re_n_q;
    assign bus.wp_n        = wp_n_q;
    assign bus.dq_out      = dq_out_q;
    assign bus.dq_oe       = dq_oe_q;
    assign bus.busy        = (state_q != FETCH);
    assign bus.err_illegal = err_ill_q;
    assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_nand_bus_seq.sv
// Directed bench for nand_bus_seq: stimulus pushes expected bytes into scoreboards,
// an independent negedge monitor pops and compares on every we_n rise and rd_valid pulse.
module tb_nand_bus_seq;
    logic clk, rst;
    int   n_chk = 0, n_fail = 0;
    int   pops = 0, we_lo = 0, re_lo = 0, rd_cnt = 0;
    logic [7:0] wr_q[$];
    logic [7:0] rd_src[$];
    logic [9:0] exp_wr[$];
    logic [7:0] exp_rd[$];

    nand_bus_if #(.NUM_CE(4), .DW(8)) bus ();

    nand_bus_seq #(
        .NUM_CE(4), .DW(8), .REP_W(8), .T_LO(2), .T_HI(2), .T_WB(8), .RB_TIMEOUT(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: expected event did not occur", nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic [31:0] i);
        bit got;
        got = 1'b0;
        bus.instr       = i;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            #4;
            got = bus.instr_ready;
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        if (!got) fail("issue_timeout");
    endtask

    task automatic wait_idle(input string nm, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < max);
        if (bus.busy) fail(nm);
    endtask

    // Core write stream: present queue head, pop on edges where wr_ready was high.
    initial begin
        bit rdy;
        forever begin
            @(negedge clk);
            bus.wr_valid = (wr_q.size() > 0);
            bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
            #4;
            rdy = bus.wr_ready;
            @(posedge clk);
            if (rdy) begin
                pops++;
                if (wr_q.size() > 0) void'(wr_q.pop_front());
            end
        end
    end

    // Monitor + flash read model.
    initial begin
        bit we_prev, re_prev;
        logic [9:0] ew;
        logic [7:0] er;
        we_prev = 1'b1;
        re_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                we_prev = 1'b1;
                re_prev = 1'b1;
            end else begin
                if (bus.we_n && !we_prev) begin
                    if (exp_wr.size() == 0) fail("wr_extra_byte");
                    else begin
                        ew = exp_wr.pop_front();
                        chk("wr_byte", 32'({bus.cle, bus.ale, bus.dq_out}), 32'(ew));
                    end
                end
                if (!bus.we_n) we_lo++;
                if (!bus.re_n) begin
                    re_lo++;
                    if (re_prev) bus.dq_in = (rd_src.size() > 0) ? rd_src.pop_front() : 8'h00;
                end
                if (bus.rd_valid) begin
                    rd_cnt++;
                    if (exp_rd.size() == 0) fail("rd_extra_byte");
                    else begin
                        er = exp_rd.pop_front();
                        chk("rd_byte", 32'(bus.rd_data), 32'(er));
                    end
                end
                we_prev = bus.we_n;
                re_prev = bus.re_n;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, w0, r0, c0, k;
        rst = 1'b1;
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        bus.rd_full = 1'b0;
        bus.rb_n = 4'hF;
        bus.dq_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ce_n", 32'(bus.ce_n), 32'hF);
        chk("rst_strobes", 32'({bus.we_n, bus.re_n}), 32'b11);
        chk("rst_wp_n", 32'(bus.wp_n), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_pins", 32'({bus.cle, bus.ale, bus.dq_oe, bus.rd_valid, bus.dq_out}), 32'h0);
        chk("rst_err", 32'({bus.err_illegal, bus.err_timeout}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        bus.instr = 32'h0; bus.instr_valid = 1'b1;
        #4 chk("t1_instr_ready", 32'(bus.instr_ready), 32'h1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("t1_ce_n", 32'(bus.ce_n), 32'hF);

        // single CMD byte on ce2
        wr_q.push_back(8'h70); exp_wr.push_back({2'b10, 8'h70});
        p0 = pops; w0 = we_lo;
        issue(32'h0002_0002);
        chk("t2_ce_n", 32'(bus.ce_n), 32'b1011);
        chk("t2_cle_oe", 32'({bus.cle, bus.ale, bus.dq_oe}), 32'b101);
        wait_idle("t2_idle_timeout", 50, n);
        chk("t2_latency", 32'(n), 32'd5);
        chk("t2_pops", 32'(pops - p0), 32'd1);
        chk("t2_we_lo_clks", 32'(we_lo - w0), 32'd2);
        chk("t2_cle_drop", 32'({bus.cle, bus.dq_oe}), 32'h0);

        // five ADDR bytes on ce0
        for (int i = 1; i <= 5; i++) begin
            wr_q.push_back(8'(i * 17));
            exp_wr.push_back({2'b01, 8'(i * 17)});
        end
        p0 = pops; w0 = we_lo;
        issue(32'h0000_0043);
        chk("t3_ce_n", 32'(bus.ce_n), 32'b1110);
        chk("t3_ale", 32'({bus.cle, bus.ale}), 32'b01);
        wait_idle("t3_idle_timeout", 100, n);
        chk("t3_latency", 32'(n), 32'd21);
        chk("t3_pops", 32'(pops - p0), 32'd5);
        chk("t3_we_lo_clks", 32'(we_lo - w0), 32'd10);

        // DIN x4 with the write stream running dry after byte 2
        wr_q.push_back(8'hA1); wr_q.push_back(8'hB2);
        exp_wr.push_back({2'b00, 8'hA1}); exp_wr.push_back({2'b00, 8'hB2});
        exp_wr.push_back({2'b00, 8'hC3}); exp_wr.push_back({2'b00, 8'hD4});
        p0 = pops; w0 = we_lo;
        issue(32'h0000_0034);
        repeat (15) @(negedge clk);
        chk("t4_stall_pops", 32'(pops - p0), 32'd2);
        chk("t4_stall_we_n", 32'(bus.we_n), 32'h1);
        chk("t4_stall_busy", 32'({bus.busy, bus.dq_oe}), 32'b11);
        wr_q.push_back(8'hC3); wr_q.push_back(8'hD4);
        wait_idle("t4_idle_timeout", 100, n);
        chk("t4_pops", 32'(pops - p0), 32'd4);
        chk("t4_we_lo_clks", 32'(we_lo - w0), 32'd8);

        // DOUT x3 with rd_full asserted after the first byte
        rd_src.push_back(8'hA5); rd_src.push_back(8'h5A); rd_src.push_back(8'h3C);
        exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A); exp_rd.push_back(8'h3C);
        c0 = rd_cnt; r0 = re_lo;
        issue(32'h0000_0025);
        chk("t5_dq_oe", 32'(bus.dq_oe), 32'h0);
        k = 0;
        while (!bus.rd_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) fail("t5_first_rd_timeout");
        bus.rd_full = 1'b1;
        w0 = re_lo;
        repeat (10) @(negedge clk);
        chk("t5_hold_re_lo", 32'(re_lo - w0), 32'd0);
        chk("t5_hold_busy", 32'({bus.busy, bus.re_n}), 32'b11);
        bus.rd_full = 1'b0;
        wait_idle("t5_idle_timeout", 100, n);
        chk("t5_rd_count", 32'(rd_cnt - c0), 32'd3);
        chk("t5_re_lo_clks", 32'(re_lo - r0), 32'd6);

        // single-cycle ops
        issue(32'h0000_0007);
        chk("wp_off", 32'(bus.wp_n), 32'h1);
        issue(32'h0003_0001);
        chk("idle_ce3", 32'(bus.ce_n), 32'b0111);
        issue(32'h0000_0006);
        chk("wp_on", 32'(bus.wp_n), 32'h0);
        issue(32'h0000_0000);
        chk("standby", 32'({bus.busy, bus.ce_n}), 32'h0F);

        // WAIT_RB with R/B already ready: leaves after the ignore window
        issue(32'h0000_0008);
        chk("rb_ce_n", 32'(bus.ce_n), 32'b1110);
        wait_idle("t6a_idle_timeout", 50, n);
        chk_rng("t6a_wb_exit", n, 8, 11);
        chk("t6a_no_timeout", 32'(bus.err_timeout), 32'h0);

        // WAIT_RB released by R/B going high
        bus.rb_n = 4'b1110;
        issue(32'h0000_0008);
        repeat (20) @(negedge clk);
        chk("t6b_waiting", 32'({bus.busy, bus.ce_n}), 32'h1E);
        bus.rb_n = 4'hF;
        wait_idle("t6b_idle_timeout", 10, n);
        chk_rng("t6b_release", n, 1, 3);
        chk("t6b_no_timeout", 32'(bus.err_timeout), 32'h0);

        // WAIT_RB timeout
        bus.rb_n = 4'b1110;
        issue(32'h0000_0008);
        wait_idle("t6c_idle_timeout", 300, n);
        chk_rng("t6c_timeout_clks", n, 100, 120);
        chk("t6c_err_timeout", 32'(bus.err_timeout), 32'h1);
        chk("t6c_ce_n", 32'(bus.ce_n), 32'b1110);
        bus.rb_n = 4'hF;

        // ce index out of range is illegal and changes nothing
        p0 = pops;
        issue(32'h0005_0002);
        chk("ill_ce_err", 32'(bus.err_illegal), 32'h1);
        chk("ill_ce_busy", 32'({bus.busy, bus.ce_n}), 32'h0E);
        repeat (3) @(negedge clk);
        chk("ill_ce_pops", 32'(pops - p0), 32'd0);

        // reset while stalled inside a DIN
        issue(32'h0002_0004);
        repeat (3) @(negedge clk);
        chk("abort_pre", 32'({bus.busy, bus.ce_n}), 32'h1B);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ce_n", 32'(bus.ce_n), 32'hF);
        chk("abort_pins", 32'({bus.busy, bus.dq_oe, bus.cle, bus.ale, bus.wp_n}), 32'h0);
        chk("abort_err_clr", 32'({bus.err_illegal, bus.err_timeout}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h0000_000F);
        chk("ill_op_err", 32'(bus.err_illegal), 32'h1);
        chk("ill_op_state", 32'({bus.busy, bus.ce_n}), 32'h0F);

        repeat (3) @(negedge clk);
        chk("wr_scoreboard_empty", 32'(exp_wr.size()), 32'd0);
        chk("rd_scoreboard_empty", 32'(exp_rd.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
